// File: rtl/kt_exec.sv
// ============================================================================
// Module   : kt_exec
// Purpose  : Console command executor; runs one console command per request
//            against memory, accumulators and the address/display registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kt_exec #(
   parameter logic [14:0] BOOT_ADDR = 15'h0000
) (
   input  logic        i_m_x,
   input  logic        rst_n,
   input  logic        i_KTQQ,
   input  logic [7:0]  i_ZLkt,
   input  logic [15:0] i_DM,
   input  logic        i_YX,
   input  logic        i_mem_ack,
   input  logic [15:0] i_mem_rdata,
   input  logic [15:0] i_acc_rdata,
   output logic        o_KTZT,
   output logic [14:0] o_Jd,
   output logic [15:0] o_Jcx,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [14:0] o_mem_addr,
   output logic [15:0] o_mem_wdata,
   output logic        o_acc_we,
   output logic [1:0]  o_acc_sel,
   output logic [15:0] o_acc_wdata,
   output logic        o_start,
   output logic        o_bad_cmd
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_EXEC   = 3'd1;
   localparam logic [2:0] S_MEM_RD = 3'd2;
   localparam logic [2:0] S_MEM_WR = 3'd3;
   localparam logic [2:0] S_ACC_RD = 3'd4;
   localparam logic [2:0] S_START  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [7:0] C_CZ  = 8'hDF;
   localparam logic [7:0] C_CZX = 8'hDC;
   localparam logic [7:0] C_XS  = 8'hF8;
   localparam logic [7:0] C_XSX = 8'hFC;
   localparam logic [7:0] C_QDZ = 8'hFB;
   localparam logic [7:0] C_YD  = 8'hFD;

   logic [2:0]  r_state;
   logic [2:0]  w_next;
   logic [7:0]  r_cmd;
   logic [15:0] r_dm;
   logic [14:0] r_jd;
   logic [15:0] r_jcx;

   logic w_accept;
   logic w_is_rd;
   logic w_is_wr;
   logic w_is_zrl;
   logic w_is_xsl;
   logic w_is_go;
   logic w_known;

   // ZRLn / XSLn carry the accumulator index in bits [4:3]
   assign w_is_zrl = (r_cmd[7:5] == 3'b001) && (r_cmd[2:0] == 3'b011);
   assign w_is_xsl = (r_cmd[7:5] == 3'b011) && (r_cmd[2:0] == 3'b111);
   assign w_is_rd  = (r_cmd == C_XS)  || (r_cmd == C_XSX);
   assign w_is_wr  = (r_cmd == C_CZ)  || (r_cmd == C_CZX);
   assign w_is_go  = (r_cmd == C_QDZ) || (r_cmd == C_YD);
   assign w_known  = w_is_rd || w_is_wr || w_is_zrl || w_is_xsl || w_is_go;
   assign w_accept = (r_state == S_IDLE) && i_KTQQ && !i_YX;

   always_ff @(posedge i_m_x or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_EXEC;
         end
         S_EXEC: begin
            if (w_is_rd)       w_next = S_MEM_RD;
            else if (w_is_wr)  w_next = S_MEM_WR;
            else if (w_is_xsl) w_next = S_ACC_RD;
            else if (w_is_go)  w_next = S_START;
            else               w_next = S_DONE;
         end
         S_MEM_RD, S_MEM_WR: begin
            if (i_mem_ack) w_next = S_DONE;
         end
         S_ACC_RD, S_START: w_next = S_DONE;
         // Holding here until the request drops guarantees a single execution
         S_DONE: begin
            if (!i_KTQQ) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_KTZT    = (r_state != S_IDLE);
      o_mem_req = 1'b0;
      o_mem_we  = 1'b0;
      o_acc_we  = 1'b0;
      o_start   = 1'b0;
      o_bad_cmd = 1'b0;
      case (r_state)
         S_EXEC: begin
            o_acc_we  = w_is_zrl;
            o_bad_cmd = !w_known;
         end
         S_MEM_RD: o_mem_req = 1'b1;
         S_MEM_WR: begin
            o_mem_req = 1'b1;
            o_mem_we  = 1'b1;
         end
         S_START:  o_start = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_m_x or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd <= 8'h00;
         r_dm  <= 16'h0000;
         r_jd  <= 15'h0000;
         r_jcx <= 16'h0000;
      end else begin
         if (w_accept) begin
            r_cmd <= i_ZLkt;
            r_dm  <= i_DM;
         end
         if (r_state == S_EXEC) begin
            case (r_cmd)
               C_XS, C_QDZ:  r_jd <= r_dm[14:0];
               C_XSX, C_CZX: r_jd <= r_jd + 15'd1;
               C_YD:         r_jd <= BOOT_ADDR;
               default: ;
            endcase
         end
         if ((r_state == S_MEM_RD) && i_mem_ack) r_jcx <= i_mem_rdata;
         if ((r_state == S_MEM_WR) && i_mem_ack) r_jcx <= r_dm;
         if (r_state == S_ACC_RD)                r_jcx <= i_acc_rdata;
      end
   end

   assign o_Jd        = r_jd;
   assign o_Jcx       = r_jcx;
   assign o_mem_addr  = r_jd;
   assign o_mem_wdata = r_dm;
   assign o_acc_wdata = r_dm;
   assign o_acc_sel   = r_cmd[4:3];

endmodule

`default_nettype wire

// File: doc/kt_exec.md
# kt_exec

Console command executor: the CPU-side responder to the console request/command pair produced by the console interface block. While the machine is halted, it accepts a console request (`i_KTQQ`) together with an 8-bit console command code (`i_ZLkt`) and switch data (`i_DM`). It then runs the command against memory, the accumulators and the address/display registers. It holds console state (`o_KTZT`) for the whole operation; this clears the request at its source.

## Interface
- `BOOT_ADDR`, default 15'h0000: start address loaded by the program-load (YD) command.
- `i_m_x`, in, 1: machine clock. All state updates on the posedge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `i_KTQQ`, in, 1: console request, level.
- `i_ZLkt`, in, 8: console command code. Sampled only on acceptance.
- `i_DM`, in, 16: console switch data. Sampled only on acceptance.
- `i_YX`, in, 1: machine running. No acceptance while 1.
- `i_mem_ack`, in, 1: memory completes the current request this cycle.
- `i_mem_rdata`, in, 16: memory read data. Valid with `i_mem_ack`.
- `i_acc_rdata`, in, 16: accumulator read data for `o_acc_sel`. Combinational.
- `o_KTZT`, out, 1: console state, busy.
- `o_Jd`, out, 15: address register.
- `o_Jcx`, out, 16: display data register.
- `o_mem_req`, out, 1: memory request, held until ack.
- `o_mem_we`, out, 1: 1 = write.
- `o_mem_addr`, out, 15: equals `o_Jd`.
- `o_mem_wdata`, out, 16: latched switch data.
- `o_acc_we`, out, 1: accumulator write strobe.
- `o_acc_sel`, out, 2: accumulator index, from code bits [4:3].
- `o_acc_wdata`, out, 16: latched switch data.
- `o_start`, out, 1: one-cycle run-start pulse. The PC is `o_Jd`.
- `o_bad_cmd`, out, 1: one-cycle pulse on an unrecognised code.

## Operation
- Command codes (hex):
  - CZ = DF, CZX = DC, XS = F8, XSX = FC.
  - QDZ = FB, YD = FD.
  - ZRLn = 23/2B/33/3B for n = 0..3.
  - XSLn = 67/6F/77/7F for n = 0..3.
  - For ZRL and XSL, n is code[4:3].
  - Any other value is a bad command.
- States: IDLE, EXEC, MEM_RD, MEM_WR, ACC_RD, START, DONE.
- IDLE: if `i_KTQQ`=1 and `i_YX`=0, latch the code into r_cmd and the switch data into r_dm, then go to EXEC.
- EXEC, per command:
  - XS: `o_Jd` ← r_dm[14:0]; go to MEM_RD.
  - XSX: `o_Jd` ← `o_Jd`+1; go to MEM_RD.
  - CZ: go to MEM_WR.
  - CZX: `o_Jd` ← `o_Jd`+1; go to MEM_WR.
  - ZRLn: `o_acc_we`=1 this cycle; go to DONE.
  - XSLn: go to ACC_RD.
  - QDZ: `o_Jd` ← r_dm[14:0]; go to START.
  - YD: `o_Jd` ← BOOT_ADDR; go to START.
  - Other: `o_bad_cmd`=1; go to DONE.
- MEM_RD: `o_mem_req`=1, `o_mem_we`=0. On `i_mem_ack`: `o_Jcx` ← `i_mem_rdata`; go to DONE. Otherwise stay.
- MEM_WR: `o_mem_req`=1, `o_mem_we`=1. On `i_mem_ack`: `o_Jcx` ← r_dm; go to DONE. Otherwise stay.
- ACC_RD: `o_Jcx` ← `i_acc_rdata`; go to DONE.
- START: `o_start`=1; go to DONE.
- DONE: go to IDLE when `i_KTQQ`=0. Otherwise wait, so one request executes exactly once.
- Address increment is 15-bit: 7FFF+1 wraps to 0000.
- `i_YX` rising mid-operation does not abort; the command completes.
- `i_KTQQ` is ignored outside IDLE and DONE.

## Timing
- Reset values:
  - State = IDLE.
  - `o_Jd`=0, `o_Jcx`=0, r_cmd=0, r_dm=0.
  - All strobes and `o_KTZT`=0.
- Reset mid-operation aborts immediately; `o_mem_req` drops asynchronously.
- Outputs depend on state (Moore). `o_mem_addr`/`o_mem_wdata`/`o_acc_wdata`/`o_acc_sel` come from registers.
- `o_KTZT`=1 in every state except IDLE. It is visible the cycle after acceptance.
- Edges counted from the acceptance edge E0, assuming `i_KTQQ` drops while `o_KTZT`=1:
  - XS/XSX/CZ/CZX with ack on the first request cycle: `o_mem_req` high in cycle E1–E2, `o_Jcx` valid after E2, IDLE after E3. Each wait cycle adds one cycle.
  - ZRL: `o_acc_we` high in E0–E1, IDLE after E2.
  - XSL: `o_Jcx` valid after E2, IDLE after E3.
  - QDZ/YD: `o_start` high in E1–E2 with `o_Jd` already updated.
- If `i_KTQQ` stays high, the block remains in DONE. `o_KTZT` stays 1 and nothing is re-executed.

## Test plan
- Reset, then `i_DM`=0123 with XS (F8); ack after 2 wait cycles, rdata=ABCD. Expect `o_Jd`=0123, `o_Jcx`=ABCD, `o_mem_req` high for 3 cycles with we=0, `o_KTZT` high until DONE exits.
- With `o_Jd`=7FFF, issue CZX (DC) with `i_DM`=5A5A. Expect a write to address 0000 with data 5A5A, `o_Jcx`=5A5A.
- ZRL2 (33) with `i_DM`=1234, then XSL2 (77) with `i_acc_rdata`=1234 for sel=2. Expect one `o_acc_we` pulse with sel=2, then `o_Jcx`=1234.
- QDZ (FB) with `i_DM`=0400: expect one `o_start` pulse with `o_Jd`=0400. YD (FD): expect one `o_start` pulse with `o_Jd`=BOOT_ADDR.
- Boundary cases:
  - Request with `i_YX`=1: expect no acceptance.
  - Code 00: expect one `o_bad_cmd` pulse and no memory or accumulator activity.
  - `i_KTQQ` held high: expect exactly one execution.
- `rst_n` low during MEM_WR before ack. Expect `o_mem_req` to drop immediately, all outputs to return to reset values, and the next request to be accepted normally.
